counter_mod_updown: RTL and testbench
=====================================

Name: counter_mod_updown

Overview:
- Parametrised up/down counter with a runtime-programmable modulus, synchronous clear and load, enable, and wrap or saturate mode.
- Successor to the fixed 7-bit enable counter. WIDTH=7 with max_val=127, up, wrap mode reproduces the legacy count sequence.
- Used as a general event, timer and index counter in the test-bench and datapath blocks.

Parameters:
- WIDTH, 7, counter width in bits (2..32).
- SAT_MODE, 0: 0 means wrap at the boundary; 1 means saturate (hold) at the boundary.
- PRESCALE, 4, enable divider ratio (2..256). Used only when the optional feature is compiled in.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  load value.
- cnt_enb  input  1  count enable.
- up_dn  input  1  direction: 1 = up, 0 = down.
- max_val  input  WIDTH  terminal value; the count range is 0..max_val.
- count  output  WIDTH  registered counter value.
- at_max  output  1  combinational: count >= max_val.
- at_zero  output  1  combinational: count == 0.
- wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap or saturation-hit step.

Behaviour:
- Reset (reset=0, asynchronous): count=0, wrap=0, prescaler state=0. Release is synchronous to clk.
- Priority per rising edge: clr > load > cnt_enb step > hold.
- clr: count<=0, wrap<=0.
- load: count<=min(load_val, max_val), wrap<=0.
- Up step:
  - If count >= max_val: wrap mode gives count<=0; saturate mode gives count<=max_val.
  - Otherwise count<=count+1.
- Down step:
  - If count == 0: wrap mode gives count<=max_val; saturate mode holds 0.
  - Else if count > max_val: count<=max_val (re-enter range).
  - Otherwise count<=count-1.
- wrap is set to 1 for exactly one cycle after any step that takes the boundary branch.
  - Saturate mode: it pulses on every enabled step taken while at the boundary.
  - Otherwise wrap<=0.
- Latency: count updates on the same edge the enable is sampled. at_max and at_zero follow count combinationally.
- max_val=0: count stays 0. Every enabled step asserts wrap on the next cycle.
- max_val changed mid-count: takes effect on the next step; there is no retroactive correction.
- up_dn changed mid-count: takes effect on the next step.
- Arithmetic is WIDTH bits, unsigned. No step may produce a value outside 0..max_val, except that count holds between steps after max_val is lowered.
- Reset asserted mid-operation clears count immediately, without waiting for a clock edge.

Optional Feature:
- Macro: COUNTER_PRESCALE_EN.
- Defined:
  - An internal divider counts cnt_enb-high cycles, 0..PRESCALE-1.
  - A step occurs only on the cycle where the divider reaches PRESCALE-1 while cnt_enb=1. The divider then returns to 0.
  - clr or load also zeroes the divider.
  - cnt_enb=0 holds the divider.
- Not defined: every cnt_enb-high cycle is a step, and no divider logic exists.

Decomposition:
- Package counter_pkg:
  - Direction constants DIR_UP=1, DIR_DOWN=0.
  - Mode constants MODE_WRAP=0, MODE_SAT=1.
  - Helper function clamp(val, max) for load clipping.
- Sub-module counter_prescaler:
  - Parameter PRESCALE.
  - Ports: clk, reset, restart, enb_in, tick_out.
  - Instantiated only under COUNTER_PRESCALE_EN.

Test Plan:
- Legacy sequence: WIDTH=7, max_val=127, up, cnt_enb=1 for 130 cycles.
  - count runs 0..127, then 0, 1.
  - wrap is high exactly one cycle, the cycle after 127->0.
- Modulus and down: max_val=9, up_dn=0, start 0, 12 steps.
  - count runs 9,8,..,0,9,8.
  - wrap pulses after each 0->9 transition.
- Saturate mode: SAT_MODE=1, max_val=5, up, 8 steps from 0.
  - count holds at 5 from step 5 onward.
  - wrap pulses on each step taken at 5.
- Priority and clamp: clr, load and cnt_enb high together with load_val=3.
  - Result is count=0.
  - Next edge with load only and load_val=20, max_val=9: count=9.
- Asynchronous reset mid-count: count=42, then reset=0 between edges.
  - count=0 and wrap=0 immediately.
  - After release, counting restarts from 0.
- Prescaler (COUNTER_PRESCALE_EN, PRESCALE=4): cnt_enb=1 for 16 cycles.
  - count advances every 4th enabled cycle, ending at count=4.
  - A cnt_enb gap of 3 cycles delays the next step by 3 cycles.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulus up/down counter.
package counter_pkg;

  // Direction encoding on up_dn
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Boundary behaviour selected by SAT_MODE
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Legal parameter ranges
  localparam int WIDTH_MIN    = 2;
  localparam int WIDTH_MAX    = 32;
  localparam int PRESCALE_MIN = 2;
  localparam int PRESCALE_MAX = 256;

  // Clip a load value into the active range 0..max_v
  function automatic logic [31:0] clamp(input logic [31:0] val, input logic [31:0] max_v);
    logic [31:0] res;
    if (val > max_v) begin
      res = max_v;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable divider: emits one tick every PRESCALE enabled cycles.
// Present only when COUNTER_PRESCALE_EN is defined.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enb_in,
  output logic tick_out
);

  localparam int DIV_W = $clog2(PRESCALE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESCALE - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1'b1);

  if ((PRESCALE < PRESCALE_MIN) || (PRESCALE > PRESCALE_MAX)) begin : g_bad_prescale
    $error("counter_prescaler: PRESCALE out of range");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_s;

  // Divider next state: restart wins, enable advances, otherwise hold
  always_comb begin
    div_d  = div_q;
    tick_s = 1'b0;
    if (restart) begin
      div_d = {DIV_W{1'b0}};
    end else if (enb_in) begin
      if (div_q == DIV_LAST) begin
        div_d  = {DIV_W{1'b0}};
        tick_s = 1'b1;
      end else begin
        div_d = div_q + DIV_ONE;
      end
    end else begin
      div_d = div_q;
    end
  end

  // Divider state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= {DIV_W{1'b0}};
    end else begin
      div_q <= div_d;
    end
  end

  // The tick must be combinational so the counter steps on the same edge
  assign tick_out = tick_s;

endmodule

// File: rtl/counter_mod_updown.sv
// Up/down counter with runtime modulus (0..max_val), clear, load,
// enable and wrap/saturate boundary behaviour.
// Optional enable prescaler: define COUNTER_PRESCALE_EN.
module counter_mod_updown
  import counter_pkg::*;
#(
  parameter int WIDTH    = 7,
  parameter int SAT_MODE = 0,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             cnt_enb,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             wrap
);

  localparam logic             SAT_EN = (SAT_MODE == MODE_SAT);
  localparam logic [WIDTH-1:0] ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1'b1);

  if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
    $error("counter_mod_updown: WIDTH out of range");
  end
  if ((SAT_MODE != MODE_WRAP) && (SAT_MODE != MODE_SAT)) begin : g_bad_mode
    $error("counter_mod_updown: SAT_MODE must be 0 or 1");
  end
  if ((PRESCALE < PRESCALE_MIN) || (PRESCALE > PRESCALE_MAX)) begin : g_bad_prescale
    $error("counter_mod_updown: PRESCALE out of range");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             step_s;
  logic [WIDTH-1:0] load_clamped_s;

`ifdef COUNTER_PRESCALE_EN
  logic restart_s;
  assign restart_s = clr | load;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart_s),
    .enb_in   (cnt_enb),
    .tick_out (step_s)
  );
`else
  assign step_s = cnt_enb;
`endif

  assign load_clamped_s = WIDTH'(clamp(32'(load_val), 32'(max_val)));

  // Next-state: clr > load > step > hold; wrap marks boundary steps
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr) begin
      count_d = ZERO;
    end else if (load) begin
      count_d = load_clamped_s;
    end else if (step_s) begin
      if (up_dn == DIR_UP) begin
        if (count_q >= max_val) begin
          count_d = SAT_EN ? max_val : ZERO;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + ONE;
        end
      end else if (up_dn == DIR_DOWN) begin
        if (count_q == ZERO) begin
          count_d = SAT_EN ? ZERO : max_val;
          wrap_d  = 1'b1;
        end else if (count_q > max_val) begin
          // max_val was lowered below the held count: step back into range
          count_d = max_val;
        end else begin
          count_d = count_q - ONE;
        end
      end else begin
        count_d = count_q;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count and wrap-pulse registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= ZERO;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count   = count_q;
  assign wrap    = wrap_q;
  assign at_max  = (count_q >= max_val);
  assign at_zero = (count_q == ZERO);

endmodule

// File: tb/tb_counter_mod_updown.sv
// Directed bench for counter_mod_updown: a wrap-mode and a saturate-mode
// instance share the same stimulus. Define COUNTER_PRESCALE_EN to build
// the prescaled variant.
module tb_counter_mod_updown;

  logic       clk;
  logic       reset;
  logic       clr;
  logic       load;
  logic [6:0] load_val;
  logic       cnt_enb;
  logic       up_dn;
  logic [6:0] max_val;

  logic [6:0] count_w, count_s;
  logic       at_max_w, at_max_s;
  logic       at_zero_w, at_zero_s;
  logic       wrap_w, wrap_s;

  int checks   = 0;
  int failures = 0;

  counter_mod_updown #(.WIDTH(7), .SAT_MODE(0), .PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
    .cnt_enb(cnt_enb), .up_dn(up_dn), .max_val(max_val),
    .count(count_w), .at_max(at_max_w), .at_zero(at_zero_w), .wrap(wrap_w)
  );

  counter_mod_updown #(.WIDTH(7), .SAT_MODE(1), .PRESCALE(4)) dut_sat (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
    .cnt_enb(cnt_enb), .up_dn(up_dn), .max_val(max_val),
    .count(count_s), .at_max(at_max_s), .at_zero(at_zero_s), .wrap(wrap_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then land on the falling edge for sampling/driving
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; clr = 1'b0; load = 1'b0; load_val = 7'd0;
    cnt_enb = 1'b0; up_dn = 1'b1; max_val = 7'd127;
    #1;
    checks++;
    if (count_w !== 7'd0 || wrap_w !== 1'b0) begin
      failures++; $display("FAIL reset_wrapdut count=%0d wrap=%0d expected 0/0", count_w, wrap_w);
    end
    checks++;
    if (count_s !== 7'd0 || wrap_s !== 1'b0) begin
      failures++; $display("FAIL reset_satdut count=%0d wrap=%0d expected 0/0", count_s, wrap_s);
    end
    checks++;
    if (at_zero_w !== 1'b1 || at_max_w !== 1'b0) begin
      failures++; $display("FAIL reset_flags at_zero=%0d at_max=%0d expected 1/0", at_zero_w, at_max_w);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_priority();
    max_val = 7'd9; load_val = 7'd7; load = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (count_w !== 7'd7) begin
      failures++; $display("FAIL prio_preload got=%0d expected=7", count_w);
    end
    clr = 1'b1; load = 1'b1; cnt_enb = 1'b1; load_val = 7'd3;
    tick();
    checks++;
    if (count_w !== 7'd0 || wrap_w !== 1'b0) begin
      failures++; $display("FAIL prio_clr_wins count=%0d wrap=%0d expected 0/0", count_w, wrap_w);
    end
    clr = 1'b0; cnt_enb = 1'b0; load = 1'b1; load_val = 7'd20;
    tick();
    checks++;
    if (count_w !== 7'd9 || at_max_w !== 1'b1) begin
      failures++; $display("FAIL prio_load_clamp count=%0d at_max=%0d expected 9/1", count_w, at_max_w);
    end
    load_val = 7'd4; cnt_enb = 1'b1;
    tick();
    checks++;
    if (count_w !== 7'd4) begin
      failures++; $display("FAIL prio_load_over_step got=%0d expected=4", count_w);
    end
    load = 1'b0; cnt_enb = 1'b0;
  endtask

`ifndef COUNTER_PRESCALE_EN
  task automatic test_legacy();
    int exp_c;
    logic exp_w;
    max_val = 7'd127; up_dn = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0; cnt_enb = 1'b1;
    for (int i = 0; i < 130; i++) begin
      tick();
      exp_c = (i + 1) % 128;
      exp_w = (i == 127);
      checks++;
      if (count_w !== 7'(exp_c) || wrap_w !== exp_w) begin
        failures++;
        $display("FAIL legacy step=%0d count=%0d wrap=%0d expected %0d/%0d", i + 1, count_w, wrap_w, exp_c, exp_w);
      end
      if (exp_c == 127) begin
        checks++;
        if (at_max_w !== 1'b1) begin
          failures++; $display("FAIL legacy_at_max got=%0d expected=1", at_max_w);
        end
      end
    end
    cnt_enb = 1'b0;
  endtask

  task automatic test_mod_down();
    int exp_c;
    logic exp_w;
    max_val = 7'd9; up_dn = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0; cnt_enb = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_c = (10 - (k % 10)) % 10;
      exp_w = ((k % 10) == 1);
      checks++;
      if (count_w !== 7'(exp_c) || wrap_w !== exp_w) begin
        failures++;
        $display("FAIL mod_down step=%0d count=%0d wrap=%0d expected %0d/%0d", k, count_w, wrap_w, exp_c, exp_w);
      end
    end
    cnt_enb = 1'b0;
  endtask

  task automatic test_saturate();
    int exp_c;
    logic exp_w;
    max_val = 7'd5; up_dn = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0; cnt_enb = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_c = (k < 5) ? k : 5;
      exp_w = (k >= 6);
      checks++;
      if (count_s !== 7'(exp_c) || wrap_s !== exp_w) begin
        failures++;
        $display("FAIL saturate step=%0d count=%0d wrap=%0d expected %0d/%0d", k, count_s, wrap_s, exp_c, exp_w);
      end
    end
    cnt_enb = 1'b0;
  endtask

  task automatic test_max_zero();
    max_val = 7'd0; clr = 1'b1;
    tick();
    clr = 1'b0; cnt_enb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      up_dn = (k < 2) ? 1'b1 : 1'b0;
      tick();
      checks++;
      if (count_w !== 7'd0 || wrap_w !== 1'b1 || at_max_w !== 1'b1) begin
        failures++;
        $display("FAIL max_zero step=%0d count=%0d wrap=%0d at_max=%0d expected 0/1/1", k, count_w, wrap_w, at_max_w);
      end
    end
    cnt_enb = 1'b0;
    tick();
    checks++;
    if (wrap_w !== 1'b0) begin
      failures++; $display("FAIL max_zero_idle wrap=%0d expected=0", wrap_w);
    end
  endtask

  task automatic test_max_change();
    max_val = 7'd9; load_val = 7'd8; load = 1'b1;
    tick();
    load = 1'b0; max_val = 7'd5;
    tick();
    checks++;
    if (count_w !== 7'd8 || at_max_w !== 1'b1) begin
      failures++; $display("FAIL maxchg_hold count=%0d at_max=%0d expected 8/1", count_w, at_max_w);
    end
    up_dn = 1'b0; cnt_enb = 1'b1;
    tick();
    checks++;
    if (count_w !== 7'd5 || wrap_w !== 1'b0) begin
      failures++; $display("FAIL maxchg_reenter count=%0d wrap=%0d expected 5/0", count_w, wrap_w);
    end
    tick();
    checks++;
    if (count_w !== 7'd4) begin
      failures++; $display("FAIL maxchg_down got=%0d expected=4", count_w);
    end
    cnt_enb = 1'b0; max_val = 7'd9; load = 1'b1;
    tick();
    load = 1'b0; max_val = 7'd5; up_dn = 1'b1; cnt_enb = 1'b1;
    tick();
    checks++;
    if (count_w !== 7'd0 || wrap_w !== 1'b1) begin
      failures++; $display("FAIL maxchg_up_wrap count=%0d wrap=%0d expected 0/1", count_w, wrap_w);
    end
    checks++;
    if (count_s !== 7'd5 || wrap_s !== 1'b1) begin
      failures++; $display("FAIL maxchg_up_sat count=%0d wrap=%0d expected 5/1", count_s, wrap_s);
    end
    cnt_enb = 1'b0;
  endtask
`else
  task automatic test_prescaler();
    int exp_c;
    max_val = 7'd127; up_dn = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0; cnt_enb = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_c = k / 4;
      checks++;
      if (count_w !== 7'(exp_c)) begin
        failures++; $display("FAIL presc_run cycle=%0d got=%0d expected=%0d", k, count_w, exp_c);
      end
    end
    cnt_enb = 1'b0;
    for (int k = 1; k <= 3; k++) tick();
    checks++;
    if (count_w !== 7'd4) begin
      failures++; $display("FAIL presc_gap_hold got=%0d expected=4", count_w);
    end
    cnt_enb = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_c = (k == 4) ? 5 : 4;
      checks++;
      if (count_w !== 7'(exp_c)) begin
        failures++; $display("FAIL presc_after_gap cycle=%0d got=%0d expected=%0d", k, count_w, exp_c);
      end
    end
    tick();
    tick();
    load = 1'b1; load_val = 7'd10;
    tick();
    load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_c = (k == 4) ? 11 : 10;
      checks++;
      if (count_w !== 7'(exp_c)) begin
        failures++; $display("FAIL presc_load_restart cycle=%0d got=%0d expected=%0d", k, count_w, exp_c);
      end
    end
    cnt_enb = 1'b0;
  endtask
`endif

  task automatic test_async_reset();
    int n_cyc;
    int exp_c;
    max_val = 7'd42; load_val = 7'd42; load = 1'b1; up_dn = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (count_w !== 7'd42) begin
      failures++; $display("FAIL areset_preload got=%0d expected=42", count_w);
    end
`ifndef COUNTER_PRESCALE_EN
    cnt_enb = 1'b1;
    tick();
    cnt_enb = 1'b0;
    checks++;
    if (count_s !== 7'd42 || wrap_s !== 1'b1) begin
      failures++; $display("FAIL areset_sat_prep count=%0d wrap=%0d expected 42/1", count_s, wrap_s);
    end
`endif
    #2 reset = 1'b0;
    #1;
    checks++;
    if (count_w !== 7'd0 || wrap_w !== 1'b0 || count_s !== 7'd0 || wrap_s !== 1'b0) begin
      failures++;
      $display("FAIL areset_immediate count=%0d/%0d wrap=%0d/%0d expected all 0", count_w, count_s, wrap_w, wrap_s);
    end
    @(negedge clk);
    reset = 1'b1; max_val = 7'd127; cnt_enb = 1'b1;
`ifdef COUNTER_PRESCALE_EN
    n_cyc = 4; exp_c = 1;
`else
    n_cyc = 3; exp_c = 3;
`endif
    for (int k = 0; k < n_cyc; k++) tick();
    cnt_enb = 1'b0;
    checks++;
    if (count_w !== 7'(exp_c)) begin
      failures++; $display("FAIL areset_restart got=%0d expected=%0d", count_w, exp_c);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
`ifndef COUNTER_PRESCALE_EN
    test_legacy();
    test_mod_down();
    test_saturate();
    test_max_zero();
    test_max_change();
`else
    test_prescaler();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
